// File: rtl/lsu_mem_stage_if.sv
// Word-wide data SRAM port driven by the MEM-stage load/store unit.
// Request side: req/we/addr/be/wdata accepted on gnt; read data returns later with rvalid.
interface lsu_mem_stage_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-3:0] m_addr;
    logic [3:0]        m_be;
    logic [DATA_W-1:0] m_wdata;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_be, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_be, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I MEM-stage load/store unit: SRAM req/gnt/rvalid handshake, store lane steering, load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses finish without a memory request and flag misalign.
//
// state  | meaning
// S_IDLE | no access in flight; a strobe launches one (stall raised combinationally)
// S_REQ  | m_req high, request fields held until m_gnt
// S_WAIT | read granted, waiting for m_rvalid
// S_DONE | done pulse, stall low; strobes still present belong to the finished instruction
module lsu_mem_stage #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        funct3,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              misalign,
    lsu_mem_stage_if.master   mem
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              mis_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              size_h;
    logic              size_w;
    logic [1:0]        off_d;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic              mis_d;
    logic              launch;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_ext;

    // Size decode: funct3[1] set covers W and the undefined encodings, all treated as W.
    always_comb begin
        size_h  = (funct3[1:0] == 2'b01);
        size_w  = funct3[1];
        off_d   = addr[1:0];
        if (size_w) begin
            off_d = 2'b00;
        end else if (size_h) begin
            off_d[0] = 1'b0;
        end
        be_d    = 4'b1111;
        wdata_d = wr_data;
        if (size_h) begin
            wdata_d = {2{wr_data[15:0]}};
        end else if (!size_w) begin
            wdata_d = {4{wr_data[7:0]}};
        end
        if (!mem_read) begin
            if (size_h) begin
                be_d = 4'b0011 << off_d;
            end else if (!size_w) begin
                be_d = 4'b0001 << off_d;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_d = (size_h & addr[0]) | (size_w & (addr[1:0] != 2'b00));
`else
    assign mis_d = 1'b0;
`endif

    always_comb begin
        ld_byte = mem.m_rdata[{off_q, 3'b000} +: 8];
        ld_half = mem.m_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
            2'b01:   load_ext = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
            default: load_ext = mem.m_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    stall   = 1'b1;
                    launch  = 1'b1;
                    state_d = mis_d ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (mem.m_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem.m_rvalid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            mis_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                we_q    <= ~mem_read;
                waddr_q <= addr[ADDR_W-1:2];
                be_q    <= be_d;
                wdata_q <= wdata_d;
                off_q   <= off_d;
                f3_q    <= funct3;
                mis_q   <= mis_d;
                if (mis_d) begin
                    rd_data_q <= '0;
                end
            end
            if ((state_q == S_WAIT) && mem.m_rvalid) begin
                rd_data_q <= load_ext;
            end
        end
    end

    assign done        = (state_q == S_DONE);
    assign misalign    = done & mis_q;
    assign rd_data     = rd_data_q;
    assign mem.m_req   = (state_q == S_REQ);
    assign mem.m_we    = we_q;
    assign mem.m_addr  = waddr_q;
    assign mem.m_be    = be_q;
    assign mem.m_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: byte-array reference model, SRAM responder with random gnt/rvalid delays,
// and a done-triggered scoreboard checking load data, misalign and latency.
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  funct3;
    logic        stall;
    logic        done;
    logic [31:0] rd_data;
    logic        misalign;

    lsu_mem_stage_if #(.ADDR_W(9), .DATA_W(32)) mif ();

    lsu_mem_stage #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wr_data   (wr_data),
        .funct3    (funct3),
        .stall     (stall),
        .done      (done),
        .rd_data   (rd_data),
        .misalign  (misalign),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0]  waddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          gd;
        int          rvd;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          start;
        int          lat;
    } exp_t;

    req_t        req_q[$];
    exp_t        exp_q[$];
    logic [7:0]  ref_b[0:511];
    logic [31:0] sram[0:127];
    logic [31:0] last_rd = 32'h0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_req(input req_t r);
        check("m_addr", 32'(mif.m_addr), 32'(r.waddr));
        check("m_be", 32'(mif.m_be), 32'(r.be));
        check("m_we", 32'(mif.m_we), 32'(r.we));
        if (r.we) check("m_wdata", mif.m_wdata, r.wdata);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(stall), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_misalign"}, 32'(misalign), 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_m_req"}, 32'(mif.m_req), 0);
        check({tag, "_m_we"}, 32'(mif.m_we), 0);
        check({tag, "_m_addr"}, 32'(mif.m_addr), 0);
        check({tag, "_m_be"}, 32'(mif.m_be), 0);
        check({tag, "_m_wdata"}, mif.m_wdata, 0);
    endtask

    task automatic poke(input int w, input logic [31:0] val);
        sram[w] = val;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = val[8*i +: 8];
    endtask

    // Model an access from the ISA rules, queue the expectations, drive it and hold until done.
    task automatic access(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                          input logic [2:0] f3, input int gd, input int rvd);
        int          size;
        int          ea;
        int          n;
        bit          trap;
        logic [31:0] val;
        req_t        r;
        exp_t        e;
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        ea   = a - (a % size);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (a % size) != 0;
`else
        trap = 1'b0;
`endif
        e.mis = trap;
        r.gd  = gd;
        r.rvd = rvd;
        r.waddr = 7'(ea / 4);
        r.wdata = 32'h0;
        if (trap) begin
            last_rd = 32'h0;
            e.rd    = 32'h0;
            e.lat   = 2;
        end else if (rd) begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | (32'(ref_b[ea+i]) << (8*i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
            last_rd = val;
            r.be  = 4'hF;
            r.we  = 1'b0;
            e.rd  = val;
            e.lat = 4 + gd + rvd;
        end else begin
            for (int i = 0; i < size; i++) ref_b[ea+i] = wd[8*i +: 8];
            r.be    = 4'(((1 << size) - 1) << (ea % 4));
            r.we    = 1'b1;
            r.wdata = (size == 1) ? {4{wd[7:0]}} : ((size == 2) ? {2{wd[15:0]}} : wd);
            e.rd    = last_rd;
            e.lat   = 3 + gd;
        end
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        addr      = 9'(a);
        wr_data   = wd;
        funct3    = f3;
        e.start   = cyc;
        exp_q.push_back(e);
        if (!trap) req_q.push_back(r);
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            check("stall_busy", 32'(stall), 1);
            if (trap) check("trap_no_req", 32'(mif.m_req), 0);
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: no done after %0d cycles, addr %h", n, a);
                break;
            end
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // SRAM responder: checks each request against the model, then grants / returns data.
    initial begin
        req_t r;
        mif.m_gnt    = 1'b0;
        mif.m_rvalid = 1'b0;
        mif.m_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (mif.m_req === 1'b1) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: m_req=1 addr %h, expected none", mif.m_addr);
                    mif.m_gnt = 1'b1;
                    @(negedge clk);
                    mif.m_gnt = 1'b0;
                end else begin
                    r = req_q.pop_front();
                    check_req(r);
                    repeat (r.gd) begin
                        mif.m_rvalid = 1'($urandom_range(0, 1));
                        mif.m_rdata  = $urandom;
                        @(negedge clk);
                        check("req_hold", 32'(mif.m_req), 1);
                        check_req(r);
                    end
                    mif.m_rvalid = 1'b0;
                    mif.m_gnt    = 1'b1;
                    if (mif.m_we)
                        for (int i = 0; i < 4; i++)
                            if (mif.m_be[i]) sram[mif.m_addr][8*i +: 8] = mif.m_wdata[8*i +: 8];
                    @(negedge clk);
                    mif.m_gnt = 1'b0;
                    check("req_drop", 32'(mif.m_req), 0);
                    if (!r.we) begin
                        repeat (r.rvd) @(negedge clk);
                        mif.m_rvalid = 1'b1;
                        mif.m_rdata  = sram[r.waddr];
                        @(negedge clk);
                        mif.m_rvalid = 1'b0;
                        mif.m_rdata  = $urandom;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every done pulse retires the oldest expected access.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no access outstanding");
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e.rd);
                    check("misalign", 32'(misalign), 32'(e.mis));
                    check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
                    check("stall_in_done", 32'(stall), 0);
                end
            end
        end
    end

    initial begin
        bit rd;
        bit wr;
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 9'h0;
        wr_data   = 32'h0;
        funct3    = 3'b000;
        for (int w = 0; w < 128; w++) poke(w, $urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        access(0, 1, 'h10, 32'hDEAD_BEEF, 3'b010, 0, 0);
        access(0, 1, 'h13, 32'h0000_00A5, 3'b000, 0, 0);
        poke(8, 32'h1234_F077);
        access(1, 0, 'h21, 32'h0, 3'b000, 0, 0);
        access(1, 0, 'h21, 32'h0, 3'b100, 0, 0);
        access(1, 0, 'h22, 32'h0, 3'b101, 0, 0);
        access(1, 0, 'h10, 32'h0, 3'b010, 2, 3);
        access(0, 1, 'h42, 32'h1357_9BDF, 3'b001, 1, 0);
        access(1, 0, 'h42, 32'h0, 3'b001, 0, 1);

        // Reset lands while the load waits for rvalid; the late rvalid must be ignored.
        begin
            req_t r;
            r.waddr = 7'd5;
            r.be    = 4'hF;
            r.we    = 1'b0;
            r.wdata = 32'h0;
            r.gd    = 0;
            r.rvd   = 3;
            req_q.push_back(r);
        end
        @(posedge clk); #1;
        mem_read = 1'b1;
        addr     = 9'h14;
        funct3   = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset    = 1'b1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b0;
        last_rd = 32'h0;
        repeat (6) begin
            @(negedge clk);
            check_quiet("post_reset");
        end
        access(0, 1, 'h10, 32'hCAFE_F00D, 3'b010, 0, 0);

        access(1, 0, 'h02, 32'h0, 3'b010, 0, 0);
        access(0, 1, 'h07, 32'h0BAD_F00D, 3'b001, 0, 0);
        access(1, 1, 'h30, 32'h1111_2222, 3'b110, 1, 1);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            access(rd, wr, int'($urandom_range(0, 511)), $urandom, 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        check("req_q_drained", 32'(req_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
